// File: rtl/lc3_control_unit_if.sv
// Control-unit <-> datapath/memory signal bundle.
// master: the control unit (drives loads, gates, selects, strobes).
// slave:  the datapath side (drives IR fields, BEN and front-panel levels).
interface lc3_control_unit_if;
    logic       run;
    logic       cont;
    logic [3:0] opcode;
    logic       ir_5;
    logic       ir_11;
    logic       ben;

    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic [1:0] addr2mux;
    logic       addr1mux, drmux, sr1mux, sr2mux;
    logic [1:0] aluk;
    logic       memio;
    logic       mem_rd, mem_wr;
    logic [4:0] state_dbg;

    modport master (
        input  run, cont, opcode, ir_5, ir_11, ben,
        output ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
        output gate_pc, gate_mdr, gate_alu, gate_marmux,
        output pcmux, addr2mux, addr1mux, drmux, sr1mux, sr2mux, aluk,
        output memio, mem_rd, mem_wr, state_dbg
    );

    modport slave (
        output run, cont, opcode, ir_5, ir_11, ben,
        input  ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
        input  gate_pc, gate_mdr, gate_alu, gate_marmux,
        input  pcmux, addr2mux, addr1mux, drmux, sr1mux, sr2mux, aluk,
        input  memio, mem_rd, mem_wr, state_dbg
    );
endinterface

// File: rtl/lc3_control_unit.sv
// LC-3 control unit: Moore FSM sequencing fetch/decode/execute for the lab ISA
// subset (ADD, AND, NOT, BR, JMP, JSR, LDR, STR, PAUSE) with Run/Continue control.
module lc3_control_unit #(
    parameter int unsigned MEM_WAIT = 2  // memory strobe length in cycles (1..7)
) (
    input logic             clk,
    input logic             reset,       // asynchronous, active-low
    lc3_control_unit_if.master bus
);

    typedef enum logic [4:0] {
        StHalted = 5'd0,  StF1    = 5'd1,  StF2   = 5'd2,  StF3   = 5'd3,
        StDec    = 5'd4,  StAdd   = 5'd5,  StAnd  = 5'd6,  StNot  = 5'd7,
        StBr     = 5'd8,  StBrTake= 5'd9,  StJmp  = 5'd10, StJsr1 = 5'd11,
        StJsr2   = 5'd12, StLd1   = 5'd13, StLd2  = 5'd14, StLd3  = 5'd15,
        StSt1    = 5'd16, StSt2   = 5'd17, StSt3  = 5'd18, StP1   = 5'd19,
        StP2     = 5'd20
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] wait_q, wait_d;
    state_e     fetch_next;

    // JSRR is not supported, so IR[11] has no effect on sequencing.
    logic unused_ir_11;
    assign unused_ir_11 = bus.ir_11;

    function automatic logic is_mem(input state_e s);
        return (s == StF2) || (s == StLd2) || (s == StSt3);
    endfunction

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StHalted;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic; every return to fetch halts instead if run has dropped.
    always_comb begin
        fetch_next = bus.run ? StF1 : StHalted;
        state_d    = state_q;
        unique case (state_q)
            StHalted: if (bus.run) state_d = StF1;
            StF1:     state_d = StF2;
            StF2:     if (wait_q == '0) state_d = StF3;
            StF3:     state_d = StDec;
            StDec: begin
                case (bus.opcode)
                    4'b0001: state_d = StAdd;
                    4'b0101: state_d = StAnd;
                    4'b1001: state_d = StNot;
                    4'b0000: state_d = StBr;
                    4'b1100: state_d = StJmp;
                    4'b0100: state_d = StJsr1;
                    4'b0110: state_d = StLd1;
                    4'b0111: state_d = StSt1;
                    4'b1101: state_d = StP1;
                    default: state_d = fetch_next;
                endcase
            end
            StBr:     state_d = bus.ben ? StBrTake : fetch_next;
            StAdd, StAnd, StNot, StBrTake, StJmp, StJsr2, StLd3: state_d = fetch_next;
            StJsr1:   state_d = StJsr2;
            StLd1:    state_d = StLd2;
            StLd2:    if (wait_q == '0) state_d = StLd3;
            StSt1:    state_d = StSt2;
            StSt2:    state_d = StSt3;
            StSt3:    if (wait_q == '0) state_d = fetch_next;
            StP1:     if (bus.cont) state_d = StP2;
            StP2:     if (!bus.cont) state_d = fetch_next;
            default:  state_d = StHalted;
        endcase
    end

    // Wait counter: preload on entry to a memory state, count down to zero.
    always_comb begin
        wait_d = wait_q;
        if (is_mem(state_d) && (state_d != state_q)) begin
            wait_d = 3'(MEM_WAIT - 1);
        end else if (wait_q != '0) begin
            wait_d = wait_q - 3'd1;
        end
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        bus.ld_mar      = 1'b0;
        bus.ld_mdr      = 1'b0;
        bus.ld_ir       = 1'b0;
        bus.ld_ben      = 1'b0;
        bus.ld_cc       = 1'b0;
        bus.ld_reg      = 1'b0;
        bus.ld_pc       = 1'b0;
        bus.ld_led      = 1'b0;
        bus.gate_pc     = 1'b0;
        bus.gate_mdr    = 1'b0;
        bus.gate_alu    = 1'b0;
        bus.gate_marmux = 1'b0;
        bus.pcmux       = 2'd0;
        bus.addr2mux    = 2'd0;
        bus.addr1mux    = 1'b0;
        bus.drmux       = 1'b0;
        bus.sr1mux      = 1'b0;
        bus.sr2mux      = 1'b0;
        bus.aluk        = 2'b00;
        bus.memio       = 1'b0;
        bus.mem_rd      = 1'b0;
        bus.mem_wr      = 1'b0;
        bus.state_dbg   = state_q;
        unique case (state_q)
            StF1: begin
                bus.gate_pc = 1'b1;
                bus.ld_mar  = 1'b1;
                bus.ld_pc   = 1'b1;
            end
            StF2, StLd2: begin
                bus.mem_rd = 1'b1;
                bus.memio  = 1'b1;
                bus.ld_mdr = 1'b1;
            end
            StF3: begin
                bus.gate_mdr = 1'b1;
                bus.ld_ir    = 1'b1;
            end
            StDec: bus.ld_ben = 1'b1;
            StAdd, StAnd: begin
                bus.sr1mux   = 1'b1;
                bus.sr2mux   = ~bus.ir_5;
                bus.aluk     = (state_q == StAnd) ? 2'b01 : 2'b00;
                bus.gate_alu = 1'b1;
                bus.ld_reg   = 1'b1;
                bus.ld_cc    = 1'b1;
            end
            StNot: begin
                bus.sr1mux   = 1'b1;
                bus.aluk     = 2'b10;
                bus.gate_alu = 1'b1;
                bus.ld_reg   = 1'b1;
                bus.ld_cc    = 1'b1;
            end
            StBrTake: begin
                bus.addr2mux = 2'd1;
                bus.pcmux    = 2'd2;
                bus.ld_pc    = 1'b1;
            end
            StJmp: begin
                bus.sr1mux   = 1'b1;
                bus.addr1mux = 1'b1;
                bus.addr2mux = 2'd3;
                bus.pcmux    = 2'd2;
                bus.ld_pc    = 1'b1;
            end
            StJsr1: begin
                bus.gate_pc = 1'b1;
                bus.drmux   = 1'b1;
                bus.ld_reg  = 1'b1;
            end
            StJsr2: begin
                bus.pcmux = 2'd2;
                bus.ld_pc = 1'b1;
            end
            StLd1, StSt1: begin
                bus.sr1mux      = 1'b1;
                bus.addr1mux    = 1'b1;
                bus.addr2mux    = 2'd2;
                bus.gate_marmux = 1'b1;
                bus.ld_mar      = 1'b1;
            end
            StLd3: begin
                bus.gate_mdr = 1'b1;
                bus.ld_reg   = 1'b1;
                bus.ld_cc    = 1'b1;
            end
            StSt2: begin
                bus.aluk     = 2'b11;
                bus.gate_alu = 1'b1;
                bus.ld_mdr   = 1'b1;
            end
            StSt3:   bus.mem_wr = 1'b1;
            StP1:    bus.ld_led = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lc3_control_unit.sv
// Directed, table-driven bench for lc3_control_unit (MEM_WAIT = 2).
module tb_lc3_control_unit;

    // State codes of the DUT state_dbg output.
    localparam logic [4:0] SH = 5'd0, SF1 = 5'd1, SF2 = 5'd2, SF3 = 5'd3, SDec = 5'd4;
    localparam logic [4:0] SAdd = 5'd5, SAnd = 5'd6, SNot = 5'd7, SBr = 5'd8, SBrT = 5'd9;
    localparam logic [4:0] SJmp = 5'd10, SJsr1 = 5'd11, SJsr2 = 5'd12;
    localparam logic [4:0] SLd1 = 5'd13, SLd2 = 5'd14, SLd3 = 5'd15;
    localparam logic [4:0] SSt1 = 5'd16, SSt2 = 5'd17, SSt3 = 5'd18, SP1 = 5'd19, SP2 = 5'd20;

    // Observed-output word bit fields.
    localparam logic [24:0] LdMar = 25'd1 << 24, LdMdr = 25'd1 << 23, LdIr = 25'd1 << 22;
    localparam logic [24:0] LdBen = 25'd1 << 21, LdCc = 25'd1 << 20, LdReg = 25'd1 << 19;
    localparam logic [24:0] LdPc = 25'd1 << 18, LdLed = 25'd1 << 17, GatePc = 25'd1 << 16;
    localparam logic [24:0] GateMdr = 25'd1 << 15, GateAlu = 25'd1 << 14;
    localparam logic [24:0] GateMarmux = 25'd1 << 13, Pcmux2 = 25'd2 << 11;
    localparam logic [24:0] A2Sext9 = 25'd1 << 9, A2Sext6 = 25'd2 << 9, A2Zero = 25'd3 << 9;
    localparam logic [24:0] Addr1 = 25'd1 << 8, Drmux = 25'd1 << 7, Sr1 = 25'd1 << 6;
    localparam logic [24:0] Sr2 = 25'd1 << 5, AlukAnd = 25'd1 << 3, AlukNot = 25'd2 << 3;
    localparam logic [24:0] AlukPass = 25'd3 << 3, Memio = 25'd1 << 2, MemRd = 25'd1 << 1;
    localparam logic [24:0] MemWr = 25'd1;

    localparam logic [24:0] EF1 = GatePc | LdMar | LdPc;
    localparam logic [24:0] ERd = MemRd | Memio | LdMdr;
    localparam logic [24:0] EF3 = GateMdr | LdIr;
    localparam logic [24:0] EAlu = Sr1 | GateAlu | LdReg | LdCc;
    localparam logic [24:0] EAddr = Sr1 | Addr1 | A2Sext6 | GateMarmux | LdMar;

    typedef struct {
        string       name;
        logic        run;
        logic        cont;
        logic [3:0]  op;
        logic        ir5;
        logic        ben;
        logic [4:0]  st;
        logic [24:0] out;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[$];

    lc3_control_unit_if bus ();

    lc3_control_unit #(.MEM_WAIT(2)) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [24:0] obs;
    logic [3:0]  gates;
    assign obs = {bus.ld_mar, bus.ld_mdr, bus.ld_ir, bus.ld_ben, bus.ld_cc, bus.ld_reg,
                  bus.ld_pc, bus.ld_led, bus.gate_pc, bus.gate_mdr, bus.gate_alu,
                  bus.gate_marmux, bus.pcmux, bus.addr2mux, bus.addr1mux, bus.drmux,
                  bus.sr1mux, bus.sr2mux, bus.aluk, bus.memio, bus.mem_rd, bus.mem_wr};
    assign gates = {bus.gate_pc, bus.gate_mdr, bus.gate_alu, bus.gate_marmux};

    a_one_gate: assert property (@(posedge clk) disable iff (!reset) $countones(gates) <= 1)
        else $error("FAIL gate_exclusive: gates=%b", gates);

    function automatic vec_t mk(input string nm, input logic r, input logic c,
                                input logic [3:0] op, input logic i5, input logic b,
                                input logic [4:0] st, input logic [24:0] o);
        vec_t v;
        v.name = nm; v.run = r; v.cont = c; v.op = op; v.ir5 = i5; v.ben = b;
        v.st = st; v.out = o;
        return v;
    endfunction

    task automatic add(input string nm, input logic r, input logic c, input logic [3:0] op,
                       input logic i5, input logic b, input logic [4:0] st,
                       input logic [24:0] o);
        vecs.push_back(mk(nm, r, c, op, i5, b, st, o));
    endtask

    // F1, two-cycle F2, F3, DEC with the given IR fields and run=1.
    task automatic add_fetch(input logic [3:0] op, input logic i5, input logic b);
        add("f1", 1, 0, op, i5, b, SF1, EF1);
        add("f2a", 1, 0, op, i5, b, SF2, ERd);
        add("f2b", 1, 0, op, i5, b, SF2, ERd);
        add("f3", 1, 0, op, i5, b, SF3, EF3);
        add("dec", 1, 0, op, i5, b, SDec, LdBen);
    endtask

    task automatic check(input string nm, input logic [4:0] st, input logic [24:0] o);
        n_vec++;
        if (bus.state_dbg !== st || obs !== o) begin
            n_err++;
            $display("FAIL %s: got state=%0d out=%h, expected state=%0d out=%h",
                     nm, bus.state_dbg, obs, st, o);
        end
        n_vec++;
        if ($countones(gates) > 1) begin
            n_err++;
            $display("FAIL %s_gates: got gates=%b, expected at most one set", nm, gates);
        end
    endtask

    // One cycle: drive inputs after the falling edge, check the current state's outputs.
    task automatic step(input vec_t v);
        @(negedge clk);
        bus.run = v.run; bus.cont = v.cont; bus.opcode = v.op;
        bus.ir_5 = v.ir5; bus.ben = v.ben;
        #1;
        check(v.name, v.st, v.out);
    endtask

    task automatic flush();
        while (vecs.size() > 0) step(vecs.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        bus.run = 1'b0; bus.cont = 1'b0; bus.opcode = 4'b0001;
        bus.ir_5 = 1'b1; bus.ir_11 = 1'b1; bus.ben = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset", SH, '0);
        reset = 1'b1;

        // Main vector table.
        for (int i = 0; i < 10; i++) add("halt_idle", 0, 0, 4'b0001, 1, 0, SH, '0);
        add("halt_run", 1, 0, 4'b0001, 1, 0, SH, '0);
        add_fetch(4'b0001, 1, 0);
        add("add_imm", 1, 0, 4'b0001, 1, 0, SAdd, EAlu);
        add_fetch(4'b0001, 0, 0);
        add("add_reg", 1, 0, 4'b0001, 0, 0, SAdd, EAlu | Sr2);
        add_fetch(4'b0101, 1, 0);
        add("and_imm", 1, 0, 4'b0101, 1, 0, SAnd, EAlu | AlukAnd);
        add_fetch(4'b0101, 0, 0);
        add("and_reg", 1, 0, 4'b0101, 0, 0, SAnd, EAlu | AlukAnd | Sr2);
        add_fetch(4'b1001, 0, 0);
        add("not", 1, 0, 4'b1001, 0, 0, SNot, EAlu | AlukNot);
        add_fetch(4'b0000, 0, 0);
        add("br_nt", 1, 0, 4'b0000, 0, 0, SBr, '0);
        add_fetch(4'b0000, 0, 1);
        add("br_t", 1, 0, 4'b0000, 0, 1, SBr, '0);
        add("br_take", 1, 0, 4'b0000, 0, 1, SBrT, A2Sext9 | Pcmux2 | LdPc);
        add_fetch(4'b1100, 0, 0);
        add("jmp", 1, 0, 4'b1100, 0, 0, SJmp, Sr1 | Addr1 | A2Zero | Pcmux2 | LdPc);
        add_fetch(4'b0100, 0, 0);
        add("jsr1", 1, 0, 4'b0100, 0, 0, SJsr1, GatePc | Drmux | LdReg);
        add("jsr2", 1, 0, 4'b0100, 0, 0, SJsr2, Pcmux2 | LdPc);
        add_fetch(4'b0110, 0, 0);
        add("ld1", 1, 0, 4'b0110, 0, 0, SLd1, EAddr);
        add("ld2a", 1, 0, 4'b0110, 0, 0, SLd2, ERd);
        add("ld2b", 1, 0, 4'b0110, 0, 0, SLd2, ERd);
        add("ld3", 1, 0, 4'b0110, 0, 0, SLd3, GateMdr | LdReg | LdCc);
        add_fetch(4'b0111, 0, 0);
        add("st1", 1, 0, 4'b0111, 0, 0, SSt1, EAddr);
        add("st2", 1, 0, 4'b0111, 0, 0, SSt2, AlukPass | GateAlu | LdMdr);
        add("st3a", 1, 0, 4'b0111, 0, 0, SSt3, MemWr);
        add("st3b", 1, 0, 4'b0111, 0, 0, SSt3, MemWr);
        add_fetch(4'b1000, 0, 0);           // illegal opcode falls straight back to fetch
        add_fetch(4'b1001, 0, 0);
        add("not_stop", 0, 0, 4'b1001, 0, 0, SNot, EAlu | AlukNot);
        add("halted_a", 0, 0, 4'b1001, 0, 0, SH, '0);
        add("halted_b", 0, 0, 4'b1001, 0, 0, SH, '0);
        flush();

        // PAUSE: hold in P1 while cont=0, one instruction per cont press.
        add("p_run", 1, 0, 4'b1101, 0, 0, SH, '0);
        add_fetch(4'b1101, 0, 0);
        for (int i = 0; i < 20; i++) add("p1_hold", 1, 0, 4'b1101, 0, 0, SP1, LdLed);
        add("p1_cont", 1, 1, 4'b1101, 0, 0, SP1, LdLed);
        for (int i = 0; i < 3; i++) add("p2_hold", 1, 1, 4'b1101, 0, 0, SP2, '0);
        add("p2_rel", 1, 0, 4'b1101, 0, 0, SP2, '0);
        // LDR, interrupted by reset in the second LD2 cycle.
        add_fetch(4'b0110, 0, 0);
        add("rld1", 1, 0, 4'b0110, 0, 0, SLd1, EAddr);
        add("rld2a", 1, 0, 4'b0110, 0, 0, SLd2, ERd);
        add("rld2b", 0, 0, 4'b0110, 0, 0, SLd2, ERd);
        flush();
        #2;
        reset = 1'b0;
        #1;
        check("rst_async", SH, '0);
        @(negedge clk);
        #1;
        check("rst_hold", SH, '0);
        reset = 1'b1;
        add("post_rst_a", 0, 0, 4'b0001, 1, 0, SH, '0);
        add("post_rst_b", 1, 0, 4'b0001, 1, 0, SH, '0);
        add_fetch(4'b0001, 1, 0);
        add("post_add", 1, 0, 4'b0001, 1, 0, SAdd, EAlu);
        add("post_f1", 1, 0, 4'b0001, 1, 0, SF1, EF1);
        flush();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lc3_control_unit.md
Name: lc3_control_unit

Overview:
Moore FSM that sequences the LC-3 datapath through fetch, decode and execute. It drives every load, gate and mux-select input of the datapath and the memory read/write strobes, and it consumes IR[15:11] and IR[5] plus BEN. It supports the lab ISA subset ADD, AND, NOT, BR, JMP, JSR, LDR, STR and PAUSE, with Run/Continue front-panel control.

Parameters:
MEM_WAIT, 2, cycles a memory read/write strobe is held before the next state (1..7)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low
run  in  1  level; leaves HALTED
cont  in  1  level; resumes from PAUSE
opcode  in  4  IR[15:12]
ir_5  in  1  IR[5], immediate select
ir_11  in  1  IR[11], JSR vs JSRR (JSRR unsupported: treated as JSR)
ben  in  1  branch-enable from datapath
ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led  out  1 each  datapath loads
gate_pc, gate_mdr, gate_alu, gate_marmux  out  1 each  bus drivers, at most one high
pcmux  out  2  0 PC+1, 1 bus, 2 adder
addr2mux  out  2  0 SEXT11, 1 SEXT9, 2 SEXT6, 3 zero
addr1mux, drmux, sr1mux, sr2mux  out  1 each  addr1: 0 PC/1 SR1; dr: 0 IR[11:9]/1 R7; sr1: 0 IR[11:9]/1 IR[8:6]; sr2: 0 imm5/1 SR2
aluk  out  2  00 ADD, 01 AND, 10 NOT, 11 PASS-A
memio  out  1  1 = MDR loads from memory
mem_rd, mem_wr  out  1 each  memory strobes
state_dbg  out  5  current state code

Behaviour:
- Reset (async, reset=0): state HALTED; all outputs 0; wait counter 0. Release is synchronous to clk.
- Outputs are a pure function of the state register (Moore). Unlisted outputs are 0 in every state.
- Wait counter: loads MEM_WAIT-1 on entry to MEM_RD or MEM_WR and decrements each cycle. The state advances when the counter is 0. mem_rd/mem_wr stay high for exactly MEM_WAIT cycles.
- State list, with the outputs asserted in each:
  - HALTED: no outputs. Goes to F1 when run=1.
  - F1: gate_pc, ld_mar, ld_pc, pcmux=0. Goes to F2.
  - F2 (MEM_RD, fetch): mem_rd, memio, ld_mdr. Goes to F3 when the counter reaches 0.
  - F3: gate_mdr, ld_ir. Goes to DEC.
  - DEC: ld_ben. Branches on opcode; illegal opcodes return to F1.
  - ADD(0001)/AND(0101): sr1mux=1, sr2mux=~ir_5, aluk=00/01, gate_alu, ld_reg, drmux=0, ld_cc. Goes to F1.
  - NOT(1001): sr1mux=1, aluk=10, gate_alu, ld_reg, ld_cc. Goes to F1.
  - BR(0000): goes to BR_TAKE if ben=1, else F1. BR_TAKE: addr1mux=0, addr2mux=1, pcmux=2, ld_pc. Goes to F1.
  - JMP(1100): sr1mux=1, addr1mux=1, addr2mux=3, pcmux=2, ld_pc. Goes to F1.
  - JSR(0100): JSR1 does gate_pc, drmux=1, ld_reg (R7←PC). JSR2 does addr1mux=0, addr2mux=0, pcmux=2, ld_pc. Goes to F1.
  - LDR(0110):
    - LD1: sr1mux=1, addr1mux=1, addr2mux=2, gate_marmux, ld_mar.
    - LD2: MEM_RD as F2.
    - LD3: gate_mdr, ld_reg, drmux=0, ld_cc. Goes to F1.
  - STR(0111):
    - ST1: as LD1.
    - ST2: sr1mux=0, aluk=11, gate_alu, ld_mdr, memio=0.
    - ST3 (MEM_WR): mem_wr. Goes to F1 when the counter reaches 0.
  - PAUSE(1101):
    - P1: ld_led. Holds while cont=0, goes to P2 when cont=1.
    - P2: waits for cont=0, then goes to F1 (edge-style handshake, one instruction per press).
- run=0 is sampled only in F1 entry decision: if run=0 when leaving F3's successor into F1, the FSM goes to HALTED instead. An instruction always completes once fetched.
- Bus exclusivity: every state asserts at most one gate_* signal. The verifier must assert this every cycle.
- Reset mid-memory-access: strobes drop immediately (async) and the FSM goes to HALTED. No partial write is re-issued.

Test Plan:
- Reset low for 3 cycles, run=0 → all outputs 0, state_dbg=HALTED, stays put for 10 cycles.
- run=1, opcode=0001, ir_5=1, MEM_WAIT=2 → F1, then F2 with mem_rd high for exactly 2 cycles, F3, DEC, ADD with sr2mux=0 and ld_reg=ld_cc=1. Total 6 cycles back to F1.
- opcode=0000 with ben=0 → DEC, BR, F1 with no ld_pc. With ben=1 → BR_TAKE with pcmux=2, addr2mux=1, ld_pc=1.
- opcode=0111 → ST1 (gate_marmux, ld_mar), ST2 (aluk=11, ld_mdr, memio=0), ST3 with mem_wr high MEM_WAIT cycles. The one-gate assertion holds throughout.
- opcode=1101, cont held 0 for 20 cycles → stays P1 with ld_led=1. cont=1 goes to P2 and holds. cont=0 goes to F1.
- Reset asserted during the 2nd cycle of LD2 → mem_rd falls in the same cycle (asynchronous), state goes to HALTED, all outputs 0.
